mem_arbiter: RTL and testbench

//  Shares the single memory port between the CPU control sequencer and a

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between the CPU sequencer and the debug/loader port.
// Latency: req sampled at edge k drives the strobe from cycle k+1; done follows mem_ready by one cycle.
// Backpressure: requesters hold req until done; losing or late requests wait and are never dropped.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TIMEOUT  = 15,
    parameter int CPU_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_err,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_done,
    output logic          dbg_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int            CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic          rr_q, rr_d;
    logic          grant_dbg;
    logic [DW-1:0] rd_val;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d, cpu_rdata_d, dbg_rdata_d;
    logic          read_d, write_d, busy_d, owner_d;
    logic          cpu_done_d, cpu_err_d, dbg_done_d, dbg_err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            rr_q      <= 1'b1;  // "dbg granted last", so CPU wins the first tie
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            cpu_rdata <= '0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            dbg_rdata <= '0;
            dbg_done  <= 1'b0;
            dbg_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            rr_q      <= rr_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_read  <= read_d;
            mem_write <= write_d;
            busy      <= busy_d;
            owner     <= owner_d;
            cpu_rdata <= cpu_rdata_d;
            cpu_done  <= cpu_done_d;
            cpu_err   <= cpu_err_d;
            dbg_rdata <= dbg_rdata_d;
            dbg_done  <= dbg_done_d;
            dbg_err   <= dbg_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        rr_d        = rr_q;
        addr_d      = mem_addr;
        wdata_d     = mem_wdata;
        read_d      = 1'b0;
        write_d     = 1'b0;
        owner_d     = owner;
        cpu_rdata_d = cpu_rdata;
        dbg_rdata_d = dbg_rdata;
        cpu_done_d  = 1'b0;
        cpu_err_d   = 1'b0;
        dbg_done_d  = 1'b0;
        dbg_err_d   = 1'b0;
        grant_dbg   = 1'b0;
        rd_val      = '0;

        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    grant_dbg = dbg_req && (!cpu_req || (CPU_PRIO == 0 && !rr_q));
                    owner_d   = grant_dbg;
                    we_d      = grant_dbg ? dbg_we    : cpu_we;
                    addr_d    = grant_dbg ? dbg_addr  : cpu_addr;
                    wdata_d   = grant_dbg ? dbg_wdata : cpu_wdata;
                    read_d    = !we_d;
                    write_d   = we_d;
                    cnt_d     = '0;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready || (TIMEOUT != 0 && cnt_q == LIM)) begin
                    // Writes and timeouts both return zero data.
                    rd_val  = (mem_ready && !we_q) ? mem_rdata : '0;
                    state_d = DONE;
                    if (owner) begin
                        dbg_rdata_d = rd_val;
                        dbg_done_d  = 1'b1;
                        dbg_err_d   = !mem_ready;
                    end else begin
                        cpu_rdata_d = rd_val;
                        cpu_done_d  = 1'b1;
                        cpu_err_d   = !mem_ready;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    read_d  = !we_q;
                    write_d = we_q;
                end
            end
            DONE: begin
                rr_d    = owner;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a second instance with CPU_PRIO=1 runs in lockstep
// so the fixed-priority tie-break can be observed alongside round-robin.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          cpu_done, cpu_err, dbg_done, dbg_err, mem_read, mem_write, busy, owner;

    logic [DW-1:0] p_cpu_rdata, p_dbg_rdata, p_mem_wdata;
    logic [AW-1:0] p_mem_addr;
    logic          p_cpu_done, p_cpu_err, p_dbg_done, p_dbg_err, p_mem_read, p_mem_write, p_busy, p_owner;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int            ready_delay = 0;
    int            acc_cnt     = 0;
    int            last_len    = 0;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_we;
    int            cpu_dn = 0;
    int            dbg_dn = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15), .CPU_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_done(dbg_done), .dbg_err(dbg_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .owner(owner)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15), .CPU_PRIO(1)) dut_prio (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(p_cpu_rdata), .cpu_done(p_cpu_done), .cpu_err(p_cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(p_dbg_rdata), .dbg_done(p_dbg_done), .dbg_err(p_dbg_err),
        .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_read(p_mem_read), .mem_write(p_mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(p_busy), .owner(p_owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory model: answers ready_delay cycles into a strobe (never if negative),
    // and records the length and first-cycle contents of each strobe burst.
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            if (acc_cnt == 0) begin
                s_addr  = mem_addr;
                s_wdata = mem_wdata;
                s_we    = mem_write;
            end
            mem_ready = (acc_cnt == ready_delay);
            acc_cnt++;
        end else begin
            mem_ready = 1'b0;
            if (acc_cnt != 0) last_len = acc_cnt;
            acc_cnt = 0;
        end
        if (cpu_done) cpu_dn++;
        if (dbg_done) dbg_dn++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_access(input bit port, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                             output bit err, output int lat, output int dcyc, output bit own);
        int start;
        bit seen;
        @(posedge clk); #1;
        if (!port) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end else begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end
        start = cyc;
        seen  = 1'b0;
        rdata = '0; err = 1'b0; lat = -1; dcyc = -1; own = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (port ? dbg_done : cpu_done) begin
                seen  = 1'b1;
                rdata = port ? dbg_rdata : cpu_rdata;
                err   = port ? dbg_err : cpu_err;
                own   = owner;
                dcyc  = cyc;
                lat   = cyc - start;
            end
        end
        chk("done_seen", seen, 1);
        @(posedge clk); #1;
        if (!port) cpu_req = 1'b0;
        else       dbg_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd, rdc, rdd;
        bit            er, erc, erd, own, ownc, ownd, seen;
        int            lat, latc, latd, dc, dcc, dcd, base_c, base_d;

        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        mem_rdata = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {mem_read, mem_write, busy, owner}, 0);
        chk("rst_done", {cpu_done, cpu_err, dbg_done, dbg_err}, 0);
        chk("rst_rdata", cpu_rdata, 0);
        reset = 1'b1;

        // 1: single-cycle CPU read
        ready_delay = 0; mem_rdata = 32'hDEADBEEF; last_len = 0;
        do_access(0, 0, 32'h40, 0, rd, er, lat, dc, own);
        chk("t1_rdata", rd, 32'hDEADBEEF);
        chk("t1_err", er, 0);
        chk("t1_lat", lat, 2);
        chk("t1_strobe_len", last_len, 1);
        chk("t1_we_addr", {s_we, s_addr}, {1'b0, 32'h40});
        chk("t1_owner", own, 0);

        // 5: async reset in the middle of an access (last grant was CPU)
        ready_delay = -1; base_c = cpu_dn;
        @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
        repeat (3) @(negedge clk);
        chk("t5_pre_read", mem_read, 1);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_read", mem_read, 0);
        chk("t5_rst_busy", busy, 0);
        cpu_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_no_done", cpu_dn - base_c, 0);
        chk("t5_no_err", {cpu_done, cpu_err}, 0);
        reset = 1'b1;
        ready_delay = 0;
        @(posedge clk); #1 cpu_req = 1'b1; dbg_req = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t5_grant", {busy, owner, mem_read}, 3'b101);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (cpu_done || dbg_done) begin
                seen = 1'b1;
                chk("t5_first_done", {cpu_done, dbg_done}, 2'b10);
            end
        end
        chk("t5_seen", seen, 1);
        @(posedge clk); #1 cpu_req = 1'b0; dbg_req = 1'b0;

        // 2: debug write with memory ready on the fourth strobe cycle
        ready_delay = 3; last_len = 0; base_c = cpu_dn; base_d = dbg_dn;
        do_access(1, 1, 32'h100, 32'h12345678, rd, er, lat, dc, own);
        chk("t2_strobe_len", last_len, 4);
        chk("t2_we_addr", {s_we, s_addr}, {1'b1, 32'h100});
        chk("t2_wdata", s_wdata, 32'h12345678);
        chk("t2_owner", own, 1);
        chk("t2_err_rdata", {er, rd}, 0);
        chk("t2_lat", lat, 5);
        chk("t2_done_cnt", {dbg_dn - base_d, cpu_dn - base_c}, {32'd1, 32'd0});

        // 4: timeout, then a normal access
        ready_delay = -1; mem_rdata = 32'h55; last_len = 0;
        do_access(0, 0, 32'h200, 0, rd, er, lat, dc, own);
        chk("t4_strobe_len", last_len, 15);
        chk("t4_err", er, 1);
        chk("t4_rdata", rd, 0);
        chk("t4_lat", lat, 16);
        ready_delay = 1; mem_rdata = 32'hCAFE0001;
        do_access(0, 0, 32'h204, 0, rd, er, lat, dc, own);
        chk("t4b_rdata", rd, 32'hCAFE0001);
        chk("t4b_err", er, 0);
        chk("t4b_lat", lat, 3);

        // 6: debug request raised while the CPU access is in flight
        ready_delay = 3; mem_rdata = 32'h600D; base_c = cpu_dn; base_d = dbg_dn;
        fork
            do_access(0, 0, 32'h300, 0, rdc, erc, latc, dcc, ownc);
            begin
                repeat (2) @(posedge clk);
                do_access(1, 0, 32'h304, 0, rdd, erd, latd, dcd, ownd);
            end
        join
        chk("t6_gap", dcd - dcc, 6);
        chk("t6_owners", {ownc, ownd}, 2'b01);
        chk("t6_rdata", {rdc, rdd}, {32'h600D, 32'h600D});
        chk("t6_done_cnt", {cpu_dn - base_c, dbg_dn - base_d}, {32'd1, 32'd1});

        // 3: both requesting for four rounds (last grant was dbg)
        ready_delay = 0;
        @(posedge clk); #1 cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b0; dbg_we = 1'b0;
        for (int r = 0; r < 4; r++) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (cpu_done || dbg_done) begin
                    seen = 1'b1;
                    chk($sformatf("t3_rr_round%0d", r), {owner, dbg_done, cpu_done},
                        {r[0], r[0], ~r[0]});
                    chk($sformatf("t3_prio_round%0d", r), {p_owner, p_cpu_done}, 2'b01);
                end
            end
            chk("t3_seen", seen, 1);
        end
        @(posedge clk); #1 cpu_req = 1'b0; dbg_req = 1'b0;

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
